gravity_ctrl: RTL and testbench
===============================

GRAVITY_CTRL -- requirements
Module: gravity_ctrl

Interface
REQ-001 Parameter SOFT_PERIOD, default 2_499_999: soft-drop step interval in clocks minus one (20 Hz at 50 MHz).
REQ-002 Parameter LOCK_TICKS, default 2: gravity ticks a landed piece waits before locking, range 1..15.
REQ-003 Parameter MAX_RESETS, default 15: maximum lock-delay resets per piece, range 0..15.
REQ-004 CLOCK_50  in  1  sole clock; all logic on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 tick_gravity  in  1  one-cycle gravity pulse from the gravity tick generator.
REQ-007 spawn  in  1  one-cycle pulse: a new piece is on the board.
REQ-008 soft_drop  in  1  level: player holds down.
REQ-009 hard_drop  in  1  one-cycle pulse: player requests hard drop.
REQ-010 shifted  in  1  one-cycle pulse: player moved or rotated the piece successfully.
REQ-011 move_ack  in  1  one-cycle response from the collision checker to move_req.
REQ-012 move_ok  in  1  valid with move_ack: 1 = piece moved down one row, 0 = blocked.
REQ-013 move_req  out  1  request to move the active piece down one row.
REQ-014 lock_piece  out  1  one-cycle pulse: freeze the piece into the board.
REQ-015 drop_cells  out  8  rows gained by soft or hard drop for the current piece; valid with lock_piece.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 States IDLE, WAIT, REQ, LANDED, LOCK; encoding is free.
REQ-018 IDLE: spawn -> WAIT; drop_cells, hard-drop flag, reset counter and soft counter cleared. Other inputs ignored.
REQ-019 WAIT: hard_drop -> set hard flag, go to REQ; else tick_gravity or soft step -> REQ. hard_drop wins over a same-cycle tick or soft step.
REQ-020 Soft counter: 26-bit; increments each WAIT cycle while soft_drop=1; cleared when soft_drop=0 or outside WAIT; at SOFT_PERIOD issues a soft step and clears.
REQ-021 REQ: move_req=1 registered, held until the move_ack cycle inclusive; it drops the cycle after move_ack.
REQ-022 move_ack with move_ok=1: drop_cells += 1 if hard flag set or the request came from a soft step, saturating at 255. Then: hard flag -> stay REQ (new request after one low cycle); otherwise -> WAIT.
REQ-023 move_ack with move_ok=0: hard flag -> LOCK; otherwise -> LANDED with lock counter loaded with LOCK_TICKS.
REQ-024 tick_gravity, soft steps, spawn, shifted and hard_drop arriving in REQ are ignored, not queued.
REQ-025 LANDED: tick_gravity decrements lock counter; counter reaching 0 -> LOCK.
REQ-026 LANDED: shifted with reset count < MAX_RESETS -> increment reset count, go to WAIT. At the cap, shifted is ignored.
REQ-027 LANDED: hard_drop -> set hard flag, go to REQ. It takes priority over shifted and tick in the same cycle.
REQ-028 LOCK: lock_piece=1 for exactly one cycle with drop_cells stable, then -> IDLE.
REQ-029 drop_cells holds its value in IDLE until the next spawn.
REQ-030 move_ack without a request is ignored in every state.

Reset
REQ-031 reset=1 at any clock edge, including mid-handshake: next state IDLE; move_req=0, lock_piece=0, busy=0, drop_cells=0; all counters and flags cleared.
REQ-032 reset has priority over all other inputs in the same cycle.

Verification
Bench parameters: SOFT_PERIOD=3, LOCK_TICKS=2, MAX_RESETS=1.
REQ-033 Gravity fall: spawn, tick, ack ok=1, tick, ack ok=0 -> LANDED; two ticks -> one lock_piece pulse with drop_cells=0; busy=0 next cycle.
REQ-034 Soft drop: spawn, soft_drop=1 -> move_req every ~5 cycles; 3 acks ok=1 then ok=0 -> LANDED; two ticks -> lock_piece with drop_cells=3.
REQ-035 Hard drop: spawn, hard_drop with same-cycle tick -> 4 back-to-back requests ok=1, then ok=0 -> lock_piece within 2 cycles, no tick needed, drop_cells=4.
REQ-036 Lock reset cap: land, shifted -> WAIT; land again, shifted ignored -> two ticks -> lock_piece.
REQ-037 Reset mid-op: reset asserted while move_req=1 -> next cycle move_req=0, busy=0, drop_cells=0; a late move_ack is ignored; a later spawn runs normally.
REQ-038 Saturation: hard drop with 300 successful acks -> drop_cells=255 at lock_piece.

Source files
------------

// File: rtl/gravity_ctrl.sv
// gravity_ctrl: drives the active piece downward on gravity ticks, soft-drop
// steps and hard drops, handles the collision-checker handshake, runs the
// lock delay with a bounded number of lock resets, and reports the drop score.
module gravity_ctrl #(
   parameter int SOFT_PERIOD = 2_499_999,
   parameter int LOCK_TICKS  = 2,
   parameter int MAX_RESETS  = 15
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       tick_gravity,
   input  logic       spawn,
   input  logic       soft_drop,
   input  logic       hard_drop,
   input  logic       shifted,
   input  logic       move_ack,
   input  logic       move_ok,
   output logic       move_req,
   output logic       lock_piece,
   output logic [7:0] drop_cells,
   output logic       busy
);

   localparam logic [25:0] SOFT_MAX = 26'(SOFT_PERIOD);
   localparam logic [3:0]  LOCK_LD  = 4'(LOCK_TICKS);
   localparam logic [3:0]  RST_CAP  = 4'(MAX_RESETS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_REQ,
      S_LANDED,
      S_LOCK
   } state_t;

   state_t      state_q, state_d;
   logic        move_req_q, move_req_d;
   logic        lock_piece_q, lock_piece_d;
   logic [7:0]  drop_cells_q, drop_cells_d;
   logic        hard_q, hard_d;         // hard drop in progress for this piece
   logic        soft_req_q, soft_req_d; // outstanding request was a soft step
   logic [25:0] soft_cnt_q, soft_cnt_d;
   logic [3:0]  lock_cnt_q, lock_cnt_d;
   logic [3:0]  rst_cnt_q, rst_cnt_d;

   logic soft_step;
   logic ack_v;

   // A soft step fires on the WAIT cycle where the held-down counter hits its period.
   assign soft_step = (state_q == S_WAIT) && soft_drop && (soft_cnt_q == SOFT_MAX);
   // Acks only count while a request is actually outstanding.
   assign ack_v     = move_ack && move_req_q;

   // Next-state and next-output computation for the whole controller.
   always_comb begin
      state_d      = state_q;
      move_req_d   = move_req_q;
      lock_piece_d = 1'b0;
      drop_cells_d = drop_cells_q;
      hard_d       = hard_q;
      soft_req_d   = soft_req_q;
      lock_cnt_d   = lock_cnt_q;
      rst_cnt_d    = rst_cnt_q;

      // Soft counter only runs while waiting with the key held; restarts after each step.
      if ((state_q == S_WAIT) && soft_drop) begin
         soft_cnt_d = soft_step ? 26'd0 : soft_cnt_q + 26'd1;
      end else begin
         soft_cnt_d = 26'd0;
      end

      case (state_q)
         S_IDLE: begin
            if (spawn) begin
               state_d      = S_WAIT;
               drop_cells_d = 8'd0;
               hard_d       = 1'b0;
               soft_req_d   = 1'b0;
               rst_cnt_d    = 4'd0;
            end
         end

         S_WAIT: begin
            if (hard_drop) begin
               hard_d     = 1'b1;
               soft_req_d = 1'b0;
               move_req_d = 1'b1;
               state_d    = S_REQ;
            end else if (tick_gravity || soft_step) begin
               soft_req_d = soft_step;
               move_req_d = 1'b1;
               state_d    = S_REQ;
            end
         end

         S_REQ: begin
            if (ack_v) begin
               move_req_d = 1'b0;
               if (move_ok) begin
                  if ((hard_q || soft_req_q) && (drop_cells_q != 8'hFF)) begin
                     drop_cells_d = drop_cells_q + 8'd1;
                  end
                  // Hard drop keeps falling; the request re-raises after one low cycle.
                  if (!hard_q) begin
                     state_d = S_WAIT;
                  end
               end else if (hard_q) begin
                  state_d      = S_LOCK;
                  lock_piece_d = 1'b1;
               end else begin
                  state_d    = S_LANDED;
                  lock_cnt_d = LOCK_LD;
               end
            end else if (!move_req_q) begin
               move_req_d = 1'b1;
            end
         end

         S_LANDED: begin
            if (hard_drop) begin
               hard_d     = 1'b1;
               soft_req_d = 1'b0;
               move_req_d = 1'b1;
               state_d    = S_REQ;
            end else if (shifted && (rst_cnt_q < RST_CAP)) begin
               rst_cnt_d = rst_cnt_q + 4'd1;
               state_d   = S_WAIT;
            end else if (tick_gravity) begin
               if (lock_cnt_q <= 4'd1) begin
                  lock_cnt_d   = 4'd0;
                  state_d      = S_LOCK;
                  lock_piece_d = 1'b1;
               end else begin
                  lock_cnt_d = lock_cnt_q - 4'd1;
               end
            end
         end

         S_LOCK: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register; reset overrides everything and clears all counters and flags.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q      <= S_IDLE;
         move_req_q   <= 1'b0;
         lock_piece_q <= 1'b0;
         drop_cells_q <= 8'd0;
         hard_q       <= 1'b0;
         soft_req_q   <= 1'b0;
         soft_cnt_q   <= 26'd0;
         lock_cnt_q   <= 4'd0;
         rst_cnt_q    <= 4'd0;
      end else begin
         state_q      <= state_d;
         move_req_q   <= move_req_d;
         lock_piece_q <= lock_piece_d;
         drop_cells_q <= drop_cells_d;
         hard_q       <= hard_d;
         soft_req_q   <= soft_req_d;
         soft_cnt_q   <= soft_cnt_d;
         lock_cnt_q   <= lock_cnt_d;
         rst_cnt_q    <= rst_cnt_d;
      end
   end

   assign move_req   = move_req_q;
   assign lock_piece = lock_piece_q;
   assign drop_cells = drop_cells_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_gravity_ctrl.sv
// Bench for gravity_ctrl: directed scenarios push the expected drop score of
// each piece into a queue; a monitor pops and compares on every lock_piece.
module tb_gravity_ctrl;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic       tick_gravity = 1'b0;
   logic       spawn = 1'b0;
   logic       soft_drop = 1'b0;
   logic       hard_drop = 1'b0;
   logic       shifted = 1'b0;
   logic       move_ack = 1'b0;
   logic       move_ok = 1'b0;
   logic       move_req;
   logic       lock_piece;
   logic [7:0] drop_cells;
   logic       busy;

   int total = 0;
   int bad = 0;
   int exp_q[$];
   logic lock_prev = 1'b0;

   gravity_ctrl #(
      .SOFT_PERIOD(3),
      .LOCK_TICKS (2),
      .MAX_RESETS (1)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .tick_gravity(tick_gravity),
      .spawn       (spawn),
      .soft_drop   (soft_drop),
      .hard_drop   (hard_drop),
      .shifted     (shifted),
      .move_ack    (move_ack),
      .move_ok     (move_ok),
      .move_req    (move_req),
      .lock_piece  (lock_piece),
      .drop_cells  (drop_cells),
      .busy        (busy)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One-cycle pulse on any combination of the event inputs.
   task automatic drive(input logic sp, input logic hd, input logic tk, input logic sh);
      spawn = sp; hard_drop = hd; tick_gravity = tk; shifted = sh;
      @(negedge CLOCK_50);
      spawn = 1'b0; hard_drop = 1'b0; tick_gravity = 1'b0; shifted = 1'b0;
   endtask

   // Bounded wait for move_req; n returns the number of cycles waited.
   task automatic wait_req(output int n);
      n = 0;
      while (!move_req && n < 60) begin
         @(negedge CLOCK_50);
         n++;
      end
      chk("move_req seen", int'(move_req), 1);
   endtask

   task automatic ack(input logic ok);
      move_ack = 1'b1; move_ok = ok;
      @(negedge CLOCK_50);
      move_ack = 1'b0; move_ok = 1'b0;
   endtask

   // Scoreboard monitor: every lock pulse must match the next expected score.
   always @(negedge CLOCK_50) begin
      if (lock_piece) begin
         if (exp_q.size() == 0) begin
            chk("unexpected lock_piece", 1, 0);
         end else begin
            chk("drop_cells at lock", int'(drop_cells), exp_q.pop_front());
         end
         chk("lock_piece single cycle", int'(lock_prev), 0);
      end
      lock_prev <= lock_piece;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge CLOCK_50);
      reset = 1'b0;
      chk("reset busy", int'(busy), 0);
      chk("reset move_req", int'(move_req), 0);
      chk("reset lock_piece", int'(lock_piece), 0);
      chk("reset drop_cells", int'(drop_cells), 0);

      // Gravity fall: one row, then land and lock after two ticks.
      drive(1, 0, 0, 0);
      chk("spawn busy", int'(busy), 1);
      drive(0, 0, 1, 0);
      wait_req(n);
      chk("tick req latency", n, 0);
      ack(1);
      chk("move_req drops after ack", int'(move_req), 0);
      drive(0, 0, 1, 0);
      wait_req(n);
      ack(0);
      exp_q.push_back(0);
      drive(0, 0, 1, 0);
      chk("no lock after first tick", int'(lock_piece), 0);
      drive(0, 0, 1, 0);
      @(negedge CLOCK_50);
      chk("idle after lock busy", int'(busy), 0);

      // Soft drop: steps every 4 WAIT cycles, three rows scored.
      soft_drop = 1'b1;
      drive(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         wait_req(n);
         chk("soft step spacing", n, 4);
         ack(1);
      end
      wait_req(n);
      ack(0);
      soft_drop = 1'b0;
      exp_q.push_back(3);
      drive(0, 0, 1, 0);
      drive(0, 0, 1, 0);
      repeat (3) @(negedge CLOCK_50);
      chk("drop_cells held in idle", int'(drop_cells), 3);

      // Hard drop with same-cycle tick: back-to-back requests, immediate lock.
      drive(1, 0, 0, 0);
      chk("new spawn clears drop_cells", int'(drop_cells), 0);
      drive(0, 1, 1, 0);
      for (int i = 0; i < 4; i++) begin
         wait_req(n);
         chk("hard req gap", n, (i == 0) ? 0 : 1);
         ack(1);
      end
      wait_req(n);
      exp_q.push_back(4);
      ack(0);
      @(negedge CLOCK_50);
      chk("hard lock then idle", int'(busy), 0);

      // Lock reset cap: first shift returns to WAIT, second is ignored.
      drive(1, 0, 0, 0);
      drive(0, 0, 1, 0);
      wait_req(n);
      ack(0);
      drive(0, 0, 0, 1);
      drive(0, 0, 1, 0);
      wait_req(n);
      chk("shift reset reaches req", n, 0);
      ack(0);
      drive(0, 0, 0, 1);
      drive(0, 0, 1, 0);
      chk("capped shift ignored", int'(move_req), 0);
      chk("still landed", int'(busy), 1);
      exp_q.push_back(0);
      drive(0, 0, 1, 0);
      @(negedge CLOCK_50);

      // Reset in the middle of a handshake; late ack ignored; fresh piece ok.
      drive(1, 0, 0, 0);
      drive(0, 1, 0, 0);
      for (int i = 0; i < 2; i++) begin
         wait_req(n);
         ack(1);
      end
      wait_req(n);
      reset = 1'b1;
      @(negedge CLOCK_50);
      reset = 1'b0;
      chk("mid reset move_req", int'(move_req), 0);
      chk("mid reset busy", int'(busy), 0);
      chk("mid reset drop_cells", int'(drop_cells), 0);
      ack(1);
      chk("late ack busy", int'(busy), 0);
      chk("late ack move_req", int'(move_req), 0);
      drive(1, 0, 0, 0);
      drive(0, 0, 1, 0);
      wait_req(n);
      ack(0);
      exp_q.push_back(0);
      drive(0, 0, 1, 0);
      drive(0, 0, 1, 0);
      @(negedge CLOCK_50);

      // Saturation: 300 scored rows clamp at 255.
      drive(1, 0, 0, 0);
      drive(0, 1, 0, 0);
      for (int i = 0; i < 300; i++) begin
         wait_req(n);
         ack(1);
      end
      wait_req(n);
      exp_q.push_back(255);
      ack(0);
      repeat (3) @(negedge CLOCK_50);

      chk("all locks seen", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
